// File: rtl/i_execute.sv
// rtl/i_execute.sv - pipeline execute stage: ALU, branch target, EX/MEM latch, iterative signed multiplier
module i_execute (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        ID_EX_valid,
  input  logic [31:0] ID_EX_npc,
  input  logic [31:0] ID_EX_readdat1,
  input  logic [31:0] ID_EX_readdat2,
  input  logic [31:0] ID_EX_sign_ext,
  input  logic [4:0]  ID_EX_instr_2016,
  input  logic [4:0]  ID_EX_instr_1511,
  input  logic [1:0]  ID_EX_wb_ctl,
  input  logic [2:0]  ID_EX_m_ctl,
  input  logic [3:0]  ID_EX_ex_ctl,
  input  logic        flush,
  output logic        ex_stall,
  output logic        EX_MEM_valid,
  output logic [1:0]  EX_MEM_wb_ctl,
  output logic [2:0]  EX_MEM_m_ctl,
  output logic [31:0] EX_MEM_branch_target,
  output logic        EX_MEM_zero,
  output logic [31:0] EX_MEM_alu_result,
  output logic [31:0] EX_MEM_readdat2,
  output logic [4:0]  EX_MEM_dest
);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DONE} state_t;

  state_t      state, state_nx;
  logic [4:0]  cnt;
  logic [63:0] acc;
  logic [63:0] mcand;
  logic [31:0] mplier;
  logic        sign;
  logic [31:0] hi, lo;

  logic        regdst, alusrc;
  logic [1:0]  aluop;
  logic [5:0]  funct;
  logic [31:0] op_a, op_b;
  logic [31:0] alu_result;
  logic        is_mult, accept;
  logic [31:0] a_mag, b_mag;
  logic [63:0] product;
  logic [31:0] branch_target;
  logic [4:0]  dest;

  assign regdst = ID_EX_ex_ctl[3];
  assign aluop  = ID_EX_ex_ctl[2:1];
  assign alusrc = ID_EX_ex_ctl[0];
  assign funct  = ID_EX_sign_ext[5:0];
  assign op_a   = ID_EX_readdat1;
  assign op_b   = alusrc ? ID_EX_sign_ext : ID_EX_readdat2;
  assign dest   = regdst ? ID_EX_instr_1511 : ID_EX_instr_2016;
  assign branch_target = ID_EX_npc + {ID_EX_sign_ext[29:0], 2'b00};

  assign is_mult = (aluop == 2'b10) && (funct == 6'b011000);
  assign accept  = (state == S_IDLE) && ID_EX_valid && is_mult && !flush;
  // Gated by rst_n so the stall reads low while reset is held, whatever ID/EX holds.
  assign ex_stall = rst_n && (accept || (state == S_MUL));

  // Negating 0x80000000 in 32 bits yields 0x80000000, which is the correct unsigned magnitude.
  assign a_mag   = ID_EX_readdat1[31] ? (32'd0 - ID_EX_readdat1) : ID_EX_readdat1;
  assign b_mag   = ID_EX_readdat2[31] ? (32'd0 - ID_EX_readdat2) : ID_EX_readdat2;
  assign product = sign ? (64'd0 - acc) : acc;

  always_comb begin
    alu_result = 32'd0;
    case (aluop)
      2'b00: alu_result = op_a + op_b;
      2'b01: alu_result = op_a - op_b;
      2'b10: begin
        case (funct)
          6'b100000: alu_result = op_a + op_b;
          6'b100010: alu_result = op_a - op_b;
          6'b100100: alu_result = op_a & op_b;
          6'b100101: alu_result = op_a | op_b;
          6'b101010: alu_result = {31'd0, ($signed(op_a) < $signed(op_b))};
          6'b010000: alu_result = hi;
          6'b010010: alu_result = lo;
          default:   alu_result = 32'd0;
        endcase
      end
      default: alu_result = 32'd0;
    endcase
  end

  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: if (accept) state_nx = S_MUL;
      S_MUL: begin
        if (flush)              state_nx = S_IDLE;
        else if (cnt == 5'd31)  state_nx = S_DONE;
      end
      S_DONE:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= 5'd0;
      acc    <= 64'd0;
      mcand  <= 64'd0;
      mplier <= 32'd0;
      sign   <= 1'b0;
      hi     <= 32'd0;
      lo     <= 32'd0;
    end else begin
      state <= state_nx;
      case (state)
        S_IDLE: begin
          if (accept) begin
            mcand  <= {32'd0, a_mag};
            mplier <= b_mag;
            acc    <= 64'd0;
            cnt    <= 5'd0;
            sign   <= ID_EX_readdat1[31] ^ ID_EX_readdat2[31];
          end
        end
        S_MUL: begin
          // One shift-add step: add the shifted multiplicand when the current multiplier bit is set.
          if (!flush) begin
            acc    <= acc + (mplier[0] ? mcand : 64'd0);
            mcand  <= {mcand[62:0], 1'b0};
            mplier <= {1'b0, mplier[31:1]};
            cnt    <= cnt + 5'd1;
          end
        end
        S_DONE: begin
          if (!flush) begin
            hi <= product[63:32];
            lo <= product[31:0];
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      EX_MEM_valid         <= 1'b0;
      EX_MEM_wb_ctl        <= 2'd0;
      EX_MEM_m_ctl         <= 3'd0;
      EX_MEM_branch_target <= 32'd0;
      EX_MEM_zero          <= 1'b0;
      EX_MEM_alu_result    <= 32'd0;
      EX_MEM_readdat2      <= 32'd0;
      EX_MEM_dest          <= 5'd0;
    end else if (flush || !ID_EX_valid || ex_stall) begin
      EX_MEM_valid         <= 1'b0;
      EX_MEM_wb_ctl        <= 2'd0;
      EX_MEM_m_ctl         <= 3'd0;
      EX_MEM_branch_target <= 32'd0;
      EX_MEM_zero          <= 1'b0;
      EX_MEM_alu_result    <= 32'd0;
      EX_MEM_readdat2      <= 32'd0;
      EX_MEM_dest          <= 5'd0;
    end else begin
      // A mult only gets here in its DONE cycle; it writes HI/LO, never the register file.
      EX_MEM_valid         <= 1'b1;
      EX_MEM_wb_ctl        <= is_mult ? {1'b0, ID_EX_wb_ctl[0]} : ID_EX_wb_ctl;
      EX_MEM_m_ctl         <= ID_EX_m_ctl;
      EX_MEM_branch_target <= branch_target;
      EX_MEM_zero          <= (alu_result == 32'd0);
      EX_MEM_alu_result    <= alu_result;
      EX_MEM_readdat2      <= ID_EX_readdat2;
      EX_MEM_dest          <= dest;
    end
  end

endmodule

// File: tb/tb_i_execute.sv
// tb/tb_i_execute.sv - scoreboard bench for i_execute with directed vectors
module tb_i_execute;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ID_EX_valid;
  logic [31:0] ID_EX_npc, ID_EX_readdat1, ID_EX_readdat2, ID_EX_sign_ext;
  logic [4:0]  ID_EX_instr_2016, ID_EX_instr_1511;
  logic [1:0]  ID_EX_wb_ctl;
  logic [2:0]  ID_EX_m_ctl;
  logic [3:0]  ID_EX_ex_ctl;
  logic        flush;
  logic        ex_stall;
  logic        EX_MEM_valid;
  logic [1:0]  EX_MEM_wb_ctl;
  logic [2:0]  EX_MEM_m_ctl;
  logic [31:0] EX_MEM_branch_target;
  logic        EX_MEM_zero;
  logic [31:0] EX_MEM_alu_result;
  logic [31:0] EX_MEM_readdat2;
  logic [4:0]  EX_MEM_dest;

  i_execute dut (
    .clk(clk), .rst_n(rst_n),
    .ID_EX_valid(ID_EX_valid), .ID_EX_npc(ID_EX_npc),
    .ID_EX_readdat1(ID_EX_readdat1), .ID_EX_readdat2(ID_EX_readdat2),
    .ID_EX_sign_ext(ID_EX_sign_ext),
    .ID_EX_instr_2016(ID_EX_instr_2016), .ID_EX_instr_1511(ID_EX_instr_1511),
    .ID_EX_wb_ctl(ID_EX_wb_ctl), .ID_EX_m_ctl(ID_EX_m_ctl), .ID_EX_ex_ctl(ID_EX_ex_ctl),
    .flush(flush), .ex_stall(ex_stall),
    .EX_MEM_valid(EX_MEM_valid), .EX_MEM_wb_ctl(EX_MEM_wb_ctl), .EX_MEM_m_ctl(EX_MEM_m_ctl),
    .EX_MEM_branch_target(EX_MEM_branch_target), .EX_MEM_zero(EX_MEM_zero),
    .EX_MEM_alu_result(EX_MEM_alu_result), .EX_MEM_readdat2(EX_MEM_readdat2),
    .EX_MEM_dest(EX_MEM_dest)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           due;
    string        name;
    logic [107:0] v;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [107:0] pack(logic v, logic [1:0] wb, logic [2:0] m, logic [31:0] bt,
                                        logic z, logic [31:0] res, logic [31:0] rd2, logic [4:0] dest);
    return {v, wb, m, bt, z, res, rd2, dest};
  endfunction

  function automatic logic [107:0] actual();
    return pack(EX_MEM_valid, EX_MEM_wb_ctl, EX_MEM_m_ctl, EX_MEM_branch_target,
                EX_MEM_zero, EX_MEM_alu_result, EX_MEM_readdat2, EX_MEM_dest);
  endfunction

  task automatic check(string name, logic [107:0] act, logic [107:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: compares every expectation whose edge has arrived, sampling 1 time unit after the edge.
  always @(posedge clk) begin
    #1;
    while (q.size() > 0 && q[0].due <= cyc) begin
      exp_t e;
      e = q.pop_front();
      check(e.name, actual(), e.v);
    end
  end

  task automatic drive(logic v, logic [31:0] npc, logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                       logic [4:0] f2016, logic [4:0] f1511, logic [1:0] wb, logic [2:0] m, logic [3:0] ex);
    ID_EX_valid = v;       ID_EX_npc = npc;
    ID_EX_readdat1 = rs;   ID_EX_readdat2 = rt;   ID_EX_sign_ext = imm;
    ID_EX_instr_2016 = f2016; ID_EX_instr_1511 = f1511;
    ID_EX_wb_ctl = wb;     ID_EX_m_ctl = m;       ID_EX_ex_ctl = ex;
  endtask

  task automatic idle_in();
    drive(1'b0, 32'd0, 32'd0, 32'd0, 32'd0, 5'd0, 5'd0, 2'd0, 3'd0, 4'd0);
  endtask

  task automatic push(string name, logic [107:0] v);
    exp_t e;
    e.due = cyc + 1; e.name = name; e.v = v;
    q.push_back(e);
  endtask

  task automatic push_bubble(string name);
    push(name, 108'd0);
  endtask

  task automatic alu_op(string name, logic [31:0] npc, logic [31:0] rs, logic [31:0] rt, logic [31:0] imm,
                        logic [4:0] f2016, logic [4:0] f1511, logic [1:0] wb, logic [2:0] m, logic [3:0] ex,
                        logic [31:0] exp_res, logic exp_zero, logic [31:0] exp_bt, logic [4:0] exp_dest);
    @(negedge clk);
    drive(1'b1, npc, rs, rt, imm, f2016, f1511, wb, m, ex);
    push(name, pack(1'b1, wb, m, exp_bt, exp_zero, exp_res, rt, exp_dest));
  endtask

  // mult with rd=9, rt=8, wb=11 (regwrite must be forced to 0), npc 0x300, funct 0x18 -> target 0x360.
  task automatic run_mult(string name, logic [31:0] rs, logic [31:0] rt);
    int n;
    @(negedge clk);
    drive(1'b1, 32'h300, rs, rt, 32'h18, 5'd8, 5'd9, 2'b11, 3'b000, 4'b1100);
    push_bubble({name, "_accept_bubble"});
    n = 0;
    #1;
    while (ex_stall && n < 100) begin
      n++;
      @(negedge clk);
      #1;
    end
    check({name, "_stall_cycles"}, 108'(n), 108'd33);
    push({name, "_done"}, pack(1'b1, 2'b01, 3'b000, 32'h360, 1'b1, 32'd0, rt, 5'd9));
  endtask

  task automatic mfhi(string name, logic [31:0] exp);
    alu_op(name, 32'h304, 32'd0, 32'd0, 32'h10, 5'd0, 5'd4, 2'b10, 3'd0, 4'b1100,
           exp, exp == 32'd0, 32'h344, 5'd4);
  endtask

  task automatic mflo(string name, logic [31:0] exp);
    alu_op(name, 32'h308, 32'd0, 32'd0, 32'h12, 5'd0, 5'd4, 2'b10, 3'd0, 4'b1100,
           exp, exp == 32'd0, 32'h350, 5'd4);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    idle_in();
    #12;
    check("reset_outputs", actual(), 108'd0);
    check("reset_stall", 108'(ex_stall), 108'd0);
    @(negedge clk);
    rst_n = 1'b1;
    push_bubble("idle_after_reset");

    alu_op("add", 32'h104, 32'd7, 32'hFFFFFFFE, 32'h20, 5'd3, 5'd5, 2'b10, 3'd0, 4'b1100,
           32'd5, 1'b0, 32'h184, 5'd5);
    alu_op("beq", 32'h100, 32'h1234, 32'h1234, 32'hFFFFFFFC, 5'd2, 5'd0, 2'b00, 3'b100, 4'b0010,
           32'd0, 1'b1, 32'hF0, 5'd2);
    alu_op("slt", 32'h200, 32'hFFFFFFFF, 32'd1, 32'h2A, 5'd1, 5'd6, 2'b10, 3'd0, 4'b1100,
           32'd1, 1'b0, 32'h2A8, 5'd6);
    alu_op("or", 32'h204, 32'hF0F0, 32'h0F0F, 32'h25, 5'd1, 5'd7, 2'b10, 3'd0, 4'b1100,
           32'hFFFF, 1'b0, 32'h298, 5'd7);
    alu_op("funct3f", 32'h208, 32'd9, 32'd4, 32'h3F, 5'd1, 5'd8, 2'b10, 3'd0, 4'b1100,
           32'd0, 1'b1, 32'h304, 5'd8);
    alu_op("addi_neg", 32'h20C, 32'd10, 32'd77, 32'hFFFFFFFF, 5'd11, 5'd12, 2'b10, 3'd0, 4'b0001,
           32'd9, 1'b0, 32'h208, 5'd11);
    alu_op("aluop11", 32'h210, 32'd5, 32'd6, 32'd0, 5'd13, 5'd14, 2'b10, 3'b010, 4'b0110,
           32'd0, 1'b1, 32'h210, 5'd13);
    alu_op("sub_wrap", 32'h214, 32'd3, 32'd5, 32'h22, 5'd1, 5'd15, 2'b10, 3'd0, 4'b1100,
           32'hFFFFFFFE, 1'b0, 32'h29C, 5'd15);
    alu_op("and", 32'h218, 32'hFF00FF00, 32'h0FF00FF0, 32'h24, 5'd1, 5'd16, 2'b10, 3'd0, 4'b1100,
           32'h0F000F00, 1'b0, 32'h2A8, 5'd16);

    @(negedge clk);
    drive(1'b1, 32'h104, 32'd7, 32'd1, 32'h20, 5'd3, 5'd5, 2'b10, 3'd0, 4'b1100);
    flush = 1'b1;
    push_bubble("flushed_add");
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    push_bubble("invalid_input");

    run_mult("mult_m3x7", 32'hFFFFFFFD, 32'd7);
    mfhi("mfhi_m3x7", 32'hFFFFFFFF);
    mflo("mflo_m3x7", 32'hFFFFFFEB);

    run_mult("mult_min_min", 32'h80000000, 32'h80000000);
    mfhi("mfhi_min_min", 32'h40000000);
    mflo("mflo_min_min", 32'h00000000);

    @(negedge clk);
    drive(1'b1, 32'h300, 32'd5, 32'd6, 32'h18, 5'd8, 5'd9, 2'b11, 3'b000, 4'b1100);
    repeat (10) @(negedge clk);
    flush = 1'b1;
    push_bubble("flush_mul10_bubble");
    @(negedge clk);
    flush = 1'b0;
    idle_in();
    #1;
    check("flush_stall_drop", 108'(ex_stall), 108'd0);
    mfhi("mfhi_after_flush", 32'h40000000);
    mflo("mflo_after_flush", 32'h00000000);

    @(negedge clk);
    drive(1'b1, 32'h300, 32'd2, 32'd3, 32'h18, 5'd8, 5'd9, 2'b11, 3'b000, 4'b1100);
    repeat (20) @(negedge clk);
    #1;
    check("stall_before_reset", 108'(ex_stall), 108'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("midmul_reset_outputs", actual(), 108'd0);
    check("midmul_reset_stall", 108'(ex_stall), 108'd0);
    @(negedge clk);
    idle_in();
    flush = 1'b1;
    rst_n = 1'b1;
    push_bubble("release_with_flush");
    @(negedge clk);
    flush = 1'b0;
    mfhi("mfhi_after_reset", 32'd0);
    mflo("mflo_after_reset", 32'd0);

    @(negedge clk);
    idle_in();
    repeat (3) @(negedge clk);
    check("scoreboard_drained", 108'(q.size()), 108'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
